// File: rtl/bomb_ctrl_if.sv
// Player-to-bomb handshake and bomb-to-renderer/collision bundle for one player.
// The master side is the player controller plus its consumers; the slave side is bomb_ctrl.
interface bomb_ctrl_if;
    logic       bomb_drop;
    logic [9:0] userX;
    logic [9:0] userY;
    logic [9:0] bombTileX;
    logic [9:0] bombTileY;
    logic       bomb_visible;
    logic       exploding;
    logic [9:0] bombX;
    logic [9:0] bombY;
    logic [9:0] bombXS;
    logic [9:0] bombYS;
    logic [9:0] blastVX;
    logic [9:0] blastVY;
    logic [9:0] blastVXS;
    logic [9:0] blastVYS;
    logic       busy;

    modport master (
        output bomb_drop, userX, userY,
        input  bombTileX, bombTileY, bomb_visible, exploding,
        input  bombX, bombY, bombXS, bombYS,
        input  blastVX, blastVY, blastVXS, blastVYS, busy
    );

    modport slave (
        input  bomb_drop, userX, userY,
        output bombTileX, bombTileY, bomb_visible, exploding,
        output bombX, bombY, bombXS, bombYS,
        output blastVX, blastVY, blastVXS, blastVYS, busy
    );
endinterface

// File: rtl/bomb_ctrl.sv
// Single-player bomb owner: grid-snapped drop, fuse countdown, blast hit rectangles, cooldown.
// Every output is a register updated together with the FSM state so they never disagree.
module bomb_ctrl #(
    parameter int TILE_SHIFT      = 5,
    parameter int FUSE_FRAMES     = 120,
    parameter int BLAST_FRAMES    = 30,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int BLAST_TILES     = 2,
    parameter int X_MIN           = 32,
    parameter int X_MAX           = 575,
    parameter int Y_MIN           = 32,
    parameter int Y_MAX           = 447,
    parameter int HALF_X          = 9,
    parameter int HALF_Y          = 13,
    parameter int CNT_W           = 8
) (
    input  logic        frame_clk,
    input  logic        Reset,
    bomb_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_BLAST    = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    localparam logic [10:0] TILE_PX   = 11'(1 << TILE_SHIFT);
    localparam logic [10:0] ARM_PX    = 11'(BLAST_TILES << TILE_SHIFT);
    localparam logic [9:0]  TILE_MASK = 10'((1 << TILE_SHIFT) - 1);
    localparam logic [9:0]  TILE_LAST = 10'((1 << TILE_SHIFT) - 1);

    // Centre of the sprite rounded down to the tile grid.
    function automatic logic [9:0] snap_tile(input logic [9:0] pos, input logic [9:0] half);
        logic [9:0] centre;
        centre = pos + half;
        return centre & ~TILE_MASK;
    endfunction

    // Low end of an arm; compared before subtracting so small tiles never wrap.
    function automatic logic [9:0] arm_lo(input logic [9:0] tile, input logic [10:0] lim);
        logic [10:0] t11;
        t11 = {1'b0, tile};
        if (t11 < lim + ARM_PX) begin
            return 10'(lim);
        end else begin
            return 10'(t11 - ARM_PX);
        end
    endfunction

    function automatic logic [9:0] arm_hi(input logic [9:0] tile, input logic [10:0] lim);
        logic [10:0] end11;
        end11 = {1'b0, tile} + ARM_PX + TILE_PX - 11'd1;
        if (end11 > lim) begin
            return 10'(lim);
        end else begin
            return 10'(end11);
        end
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic             drop_q_r;
    logic [9:0]       tile_x_r;
    logic [9:0]       tile_y_r;
    logic             visible_r;
    logic             exploding_r;
    logic             busy_r;
    logic [9:0]       bomb_x_r;
    logic [9:0]       bomb_y_r;
    logic [9:0]       bomb_xs_r;
    logic [9:0]       bomb_ys_r;
    logic [9:0]       blast_vx_r;
    logic [9:0]       blast_vy_r;
    logic [9:0]       blast_vxs_r;
    logic [9:0]       blast_vys_r;

    logic             req_s;
    logic [9:0]       h_lo_s;
    logic [9:0]       h_hi_s;
    logic [9:0]       v_lo_s;
    logic [9:0]       v_hi_s;
    logic [9:0]       snap_x_s;
    logic [9:0]       snap_y_s;

    assign req_s    = bus.bomb_drop & ~drop_q_r;
    assign snap_x_s = snap_tile(bus.userX, 10'(HALF_X));
    assign snap_y_s = snap_tile(bus.userY, 10'(HALF_Y));
    assign h_lo_s   = arm_lo(tile_x_r, 11'(X_MIN));
    assign h_hi_s   = arm_hi(tile_x_r, 11'(X_MAX));
    assign v_lo_s   = arm_lo(tile_y_r, 11'(Y_MIN));
    assign v_hi_s   = arm_hi(tile_y_r, 11'(Y_MAX));

    // Bomb lifecycle FSM with all outputs registered alongside the state.
    always_ff @(posedge frame_clk) begin
        // The edge detector keeps watching during reset so a held button cannot fire on release.
        drop_q_r <= bus.bomb_drop;
        if (Reset) begin
            state_r     <= ST_IDLE;
            count_r     <= CNT_W'(0);
            tile_x_r    <= 10'd0;
            tile_y_r    <= 10'd0;
            visible_r   <= 1'b0;
            exploding_r <= 1'b0;
            busy_r      <= 1'b0;
            bomb_x_r    <= 10'd0;
            bomb_y_r    <= 10'd0;
            bomb_xs_r   <= 10'd0;
            bomb_ys_r   <= 10'd0;
            blast_vx_r  <= 10'd0;
            blast_vy_r  <= 10'd0;
            blast_vxs_r <= 10'd0;
            blast_vys_r <= 10'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        state_r   <= ST_ARMED;
                        count_r   <= CNT_W'(FUSE_FRAMES - 1);
                        tile_x_r  <= snap_x_s;
                        tile_y_r  <= snap_y_s;
                        visible_r <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (count_r == CNT_W'(0)) begin
                        state_r     <= ST_BLAST;
                        count_r     <= CNT_W'(BLAST_FRAMES - 1);
                        visible_r   <= 1'b0;
                        exploding_r <= 1'b1;
                        bomb_x_r    <= h_lo_s;
                        bomb_xs_r   <= h_hi_s - h_lo_s;
                        bomb_y_r    <= tile_y_r;
                        bomb_ys_r   <= TILE_LAST;
                        blast_vx_r  <= tile_x_r;
                        blast_vxs_r <= TILE_LAST;
                        blast_vy_r  <= v_lo_s;
                        blast_vys_r <= v_hi_s - v_lo_s;
                    end else begin
                        count_r <= count_r - CNT_W'(1);
                    end
                end
                ST_BLAST: begin
                    if (count_r == CNT_W'(0)) begin
                        state_r     <= ST_COOLDOWN;
                        count_r     <= CNT_W'(COOLDOWN_FRAMES - 1);
                        exploding_r <= 1'b0;
                        bomb_x_r    <= 10'd0;
                        bomb_xs_r   <= 10'd0;
                        bomb_y_r    <= 10'd0;
                        bomb_ys_r   <= 10'd0;
                        blast_vx_r  <= 10'd0;
                        blast_vxs_r <= 10'd0;
                        blast_vy_r  <= 10'd0;
                        blast_vys_r <= 10'd0;
                    end else begin
                        count_r <= count_r - CNT_W'(1);
                    end
                end
                ST_COOLDOWN: begin
                    if (count_r == CNT_W'(0)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        count_r <= count_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    count_r     <= CNT_W'(0);
                    visible_r   <= 1'b0;
                    exploding_r <= 1'b0;
                    busy_r      <= 1'b0;
                    bomb_x_r    <= 10'd0;
                    bomb_xs_r   <= 10'd0;
                    bomb_y_r    <= 10'd0;
                    bomb_ys_r   <= 10'd0;
                    blast_vx_r  <= 10'd0;
                    blast_vxs_r <= 10'd0;
                    blast_vy_r  <= 10'd0;
                    blast_vys_r <= 10'd0;
                end
            endcase
        end
    end

    assign bus.bombTileX    = tile_x_r;
    assign bus.bombTileY    = tile_y_r;
    assign bus.bomb_visible = visible_r;
    assign bus.exploding    = exploding_r;
    assign bus.busy         = busy_r;
    assign bus.bombX        = bomb_x_r;
    assign bus.bombY        = bomb_y_r;
    assign bus.bombXS       = bomb_xs_r;
    assign bus.bombYS       = bomb_ys_r;
    assign bus.blastVX      = blast_vx_r;
    assign bus.blastVY      = blast_vy_r;
    assign bus.blastVXS     = blast_vxs_r;
    assign bus.blastVYS     = blast_vys_r;

endmodule

// File: tb/tb_bomb_ctrl.sv
// Bench for bomb_ctrl: a timeline model (frames since drop acceptance) checked every frame,
// plus directed drops whose tiles, rectangles and phase lengths are pinned by literals.
module tb_bomb_ctrl;

    localparam int TILE   = 32;
    localparam int FUSE   = 120;
    localparam int BLAST  = 30;
    localparam int COOL   = 30;
    localparam int ARM    = 2 * TILE;
    localparam int REACH  = 3 * TILE - 1;
    localparam int XMIN   = 32;
    localparam int XMAX   = 575;
    localparam int YMIN   = 32;
    localparam int YMAX   = 447;

    logic frame_clk;
    logic Reset;
    bomb_ctrl_if bus ();

    bomb_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: remembers which frame a drop was accepted on and the tile it snapped to.
    int cyc       = 0;
    int acc_cyc   = 0;
    bit active    = 1'b0;
    bit prev_drop = 1'b0;
    int mtx       = 0;
    int mty       = 0;

    always @(posedge frame_clk) begin
        cyc = cyc + 1;
        if (Reset) begin
            active = 1'b0;
            mtx    = 0;
            mty    = 0;
        end else if (bus.bomb_drop && !prev_drop &&
                     (!active || (cyc - 1 - acc_cyc) >= FUSE + BLAST + COOL)) begin
            active  = 1'b1;
            acc_cyc = cyc;
            mtx     = (((int'(bus.userX) + 9) / TILE) * TILE) % 1024;
            mty     = (((int'(bus.userY) + 13) / TILE) * TILE) % 1024;
        end
        prev_drop = bus.bomb_drop;
    end

    always @(negedge frame_clk) begin
        int e;
        bit idle, armed, blast;
        int lx, rx, ly, ry;
        if (cyc > 0) begin
            e     = cyc - acc_cyc;
            idle  = !active || e >= FUSE + BLAST + COOL;
            armed = !idle && e < FUSE;
            blast = !idle && e >= FUSE && e < FUSE + BLAST;
            lx = (mtx - ARM > XMIN) ? mtx - ARM : XMIN;
            rx = (mtx + REACH < XMAX) ? mtx + REACH : XMAX;
            ly = (mty - ARM > YMIN) ? mty - ARM : YMIN;
            ry = (mty + REACH < YMAX) ? mty + REACH : YMAX;
            check("m_tileX",    int'(bus.bombTileX),    mtx);
            check("m_tileY",    int'(bus.bombTileY),    mty);
            check("m_visible",  int'(bus.bomb_visible), int'(armed));
            check("m_exploding",int'(bus.exploding),    int'(blast));
            check("m_busy",     int'(bus.busy),         int'(!idle));
            check("m_bombX",    int'(bus.bombX),    blast ? lx      : 0);
            check("m_bombXS",   int'(bus.bombXS),   blast ? rx - lx : 0);
            check("m_bombY",    int'(bus.bombY),    blast ? mty     : 0);
            check("m_bombYS",   int'(bus.bombYS),   blast ? 31      : 0);
            check("m_blastVX",  int'(bus.blastVX),  blast ? mtx     : 0);
            check("m_blastVXS", int'(bus.blastVXS), blast ? 31      : 0);
            check("m_blastVY",  int'(bus.blastVY),  blast ? ly      : 0);
            check("m_blastVYS", int'(bus.blastVYS), blast ? ry - ly : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    task automatic drop_pulse(input int x, input int y);
        bus.userX     = 10'(x);
        bus.userY     = 10'(y);
        bus.bomb_drop = 1'b1;
        @(negedge frame_clk);
        bus.bomb_drop = 1'b0;
    endtask

    task automatic wait_expl(input bit v);
        for (int i = 0; i < 300 && bus.exploding != v; i++) @(negedge frame_clk);
        check("wait_exploding", int'(bus.exploding), int'(v));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && bus.busy; i++) @(negedge frame_clk);
        check("wait_idle", int'(bus.busy), 0);
    endtask

    task automatic run_bomb(input int x, input int y, input int etx, input int ety,
                            input int ebx, input int ebxs, input int evy, input int evys);
        int  n_vis;
        int  n_exp;
        bit  first;
        n_vis = 0;
        n_exp = 0;
        first = 1'b1;
        drop_pulse(x, y);
        check("lit_tileX", int'(bus.bombTileX), etx);
        check("lit_tileY", int'(bus.bombTileY), ety);
        for (int i = 0; i < 400 && bus.busy; i++) begin
            if (bus.bomb_visible) n_vis++;
            if (bus.exploding) begin
                n_exp++;
                if (first) begin
                    first = 1'b0;
                    check("lit_bombX",    int'(bus.bombX),    ebx);
                    check("lit_bombXS",   int'(bus.bombXS),   ebxs);
                    check("lit_bombY",    int'(bus.bombY),    ety);
                    check("lit_bombYS",   int'(bus.bombYS),   31);
                    check("lit_blastVX",  int'(bus.blastVX),  etx);
                    check("lit_blastVXS", int'(bus.blastVXS), 31);
                    check("lit_blastVY",  int'(bus.blastVY),  evy);
                    check("lit_blastVYS", int'(bus.blastVYS), evys);
                end
            end
            @(negedge frame_clk);
        end
        check("lit_idle_after", int'(bus.busy), 0);
        check("lit_armed_len",  n_vis, 120);
        check("lit_blast_len",  n_exp, 30);
    endtask

    initial begin
        Reset         = 1'b1;
        bus.bomb_drop = 1'b1;
        bus.userX     = 10'd0;
        bus.userY     = 10'd0;
        tick(2);
        check("rst_busy",  int'(bus.busy),      0);
        check("rst_tileX", int'(bus.bombTileX), 0);
        check("rst_bombX", int'(bus.bombX),     0);
        check("rst_expl",  int'(bus.exploding), 0);

        // Button still held after reset release: no rising edge, so no drop.
        Reset = 1'b0;
        tick(4);
        check("held_no_drop", int'(bus.busy), 0);
        bus.bomb_drop = 1'b0;
        tick(2);

        // Mid-field: arms span five tiles, 256..415 and 160..319.
        run_bomb(311, 227, 320, 224, 256, 159, 160, 159);
        tick(1);
        run_bomb(34, 34, 32, 32, 32, 95, 32, 95);
        tick(1);
        run_bomb(560, 430, 544, 416, 480, 95, 352, 95);
        tick(1);

        // Drops while ARMED or COOLDOWN are ignored; one right after IDLE is taken.
        drop_pulse(311, 227);
        tick(50);
        drop_pulse(34, 34);
        check("ign_armed_tileX", int'(bus.bombTileX), 320);
        check("ign_armed_vis",   int'(bus.bomb_visible), 1);
        wait_expl(1'b1);
        wait_expl(1'b0);
        tick(5);
        drop_pulse(560, 430);
        check("ign_cool_tileY", int'(bus.bombTileY), 224);
        check("ign_cool_busy",  int'(bus.busy), 1);
        wait_idle();
        drop_pulse(34, 34);
        check("reacc_busy",  int'(bus.busy), 1);
        check("reacc_tileX", int'(bus.bombTileX), 32);
        check("reacc_tileY", int'(bus.bombTileY), 32);
        wait_idle();
        tick(1);

        // Reset during BLAST clears everything on the next edge.
        drop_pulse(311, 227);
        wait_expl(1'b1);
        tick(3);
        Reset = 1'b1;
        @(negedge frame_clk);
        Reset = 1'b0;
        check("rstb_expl",    int'(bus.exploding), 0);
        check("rstb_busy",    int'(bus.busy),      0);
        check("rstb_bombX",   int'(bus.bombX),     0);
        check("rstb_bombXS",  int'(bus.bombXS),    0);
        check("rstb_blastVY", int'(bus.blastVY),   0);
        check("rstb_VYS",     int'(bus.blastVYS),  0);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
